// File: rtl/seg7_scroller.sv
// Purpose : rotating message buffer shown on an N_DIGITS-wide 7-segment window.
// Latency : hex follows a tick or a load by one cycle; control edges act one cycle later.
// Backpressure: none; single-cycle strobes and level edges are always accepted.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   msg, load             : new message (char 0 in bits [7:0]) and its load strobe
//   speed_up, speed_dn    : rising edges step the speed index up/down (saturating 0..7)
//   dir_tgl, pause_tgl    : rising edges toggle scroll direction / pause
//   hex                   : digit k = slot k, hgfedcba, active low
//   tick                  : one-cycle pulse on each scroll step
//   speed, dir, paused    : current run-time settings
//
// Optional feature: define SEG7_SCROLLER_PAUSE_BLINK_EN to blink the display while paused.
module seg7_scroller #(
    parameter int                   N_DIGITS   = 6,
    parameter int                   MSG_LEN    = 10,
    parameter int                   BASE_LOG2  = 19,
    parameter logic [2:0]           SPEED_INIT = 3'd4,
    parameter logic [MSG_LEN*8-1:0] INIT_MSG   = {MSG_LEN{8'hFF}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [MSG_LEN*8-1:0]    msg,
    input  logic                    load,
    input  logic                    speed_up,
    input  logic                    speed_dn,
    input  logic                    dir_tgl,
    input  logic                    pause_tgl,
    output logic [N_DIGITS*8-1:0]   hex,
    output logic                    tick,
    output logic [2:0]              speed,
    output logic                    dir,
    output logic                    paused
);

    // Prescaler is wide enough for the slowest period 2^(BASE_LOG2+7).
    localparam int CW = BASE_LOG2 + 7;

    logic [7:0]    slot_q [MSG_LEN];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_max;
    logic [2:0]    speed_q;
    logic [2:0]    speed_nxt;
    logic          dir_q;
    logic          paused_q;
    logic [3:0]    prev_q;
    logic [3:0]    ctrl;
    logic [3:0]    ev;
    logic          blank;

    // Bit order: {pause, dir, down, up}.
    assign ctrl = {pause_tgl, dir_tgl, speed_dn, speed_up};
    assign ev   = ctrl & ~prev_q;

    // P-1 = 2^(CW-s)-1, i.e. an all-ones mask shortened by s bits.
    assign cnt_max = {CW{1'b1}} >> speed_q;
    assign tick    = !paused_q && (cnt_q == cnt_max);

    // Simultaneous up and down edges cancel.
    always_comb begin
        speed_nxt = speed_q;
        if (ev[0] && !ev[1] && speed_q != 3'd7)
            speed_nxt = speed_q + 3'd1;
        else if (ev[1] && !ev[0] && speed_q != 3'd0)
            speed_nxt = speed_q - 3'd1;
    end

    // Prev flops reset to 1 so a key held through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= 4'b1111;
            speed_q  <= SPEED_INIT;
            dir_q    <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            prev_q   <= ctrl;
            speed_q  <= speed_nxt;
            dir_q    <= dir_q ^ ev[2];
            paused_q <= paused_q ^ ev[3];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (load || speed_nxt != speed_q)
            cnt_q <= '0;
        else if (paused_q)
            cnt_q <= cnt_q;
        else if (tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    // Load wins over a tick; rotation uses the direction registered before any
    // toggle seen in this same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++)
                slot_q[i] <= INIT_MSG[8*i +: 8];
        end else if (load) begin
            for (int i = 0; i < MSG_LEN; i++)
                slot_q[i] <= msg[8*i +: 8];
        end else if (tick) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if (!dir_q)
                    slot_q[i] <= slot_q[(i + 1) % MSG_LEN];
                else
                    slot_q[i] <= slot_q[(i + MSG_LEN - 1) % MSG_LEN];
            end
        end
    end

`ifdef SEG7_SCROLLER_PAUSE_BLINK_EN
    // Counts paused cycles; its MSB gates the display to blank.
    logic [BASE_LOG2+3:0] blink_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blink_q <= '0;
        else if (paused_q)
            blink_q <= blink_q + (BASE_LOG2+4)'(1);
        else
            blink_q <= '0;
    end

    assign blank = paused_q & blink_q[BASE_LOG2+3];
`else
    assign blank = 1'b0;
`endif

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        assign hex[8*k +: 8] = blank ? 8'hFF : slot_q[k];
    end

    assign speed  = speed_q;
    assign dir    = dir_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_seg7_scroller.sv
module tb_seg7_scroller;

    localparam int          ND   = 6;
    localparam int          ML   = 10;
    localparam int          BL   = 2;
    localparam logic [79:0] INIT = 80'h09080706050403020100;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [ML*8-1:0] msg = '0;
    logic           load = 1'b0;
    logic           speed_up = 1'b0;
    logic           speed_dn = 1'b0;
    logic           dir_tgl = 1'b0;
    logic           pause_tgl = 1'b0;
    logic [ND*8-1:0] hex;
    logic           tick;
    logic [2:0]     speed;
    logic           dir;
    logic           paused;

    int checks = 0;
    int failures = 0;

    seg7_scroller #(
        .N_DIGITS(ND), .MSG_LEN(ML), .BASE_LOG2(BL),
        .SPEED_INIT(3'd4), .INIT_MSG(INIT)
    ) dut (
        .clk(clk), .reset(reset), .msg(msg), .load(load),
        .speed_up(speed_up), .speed_dn(speed_dn),
        .dir_tgl(dir_tgl), .pause_tgl(pause_tgl),
        .hex(hex), .tick(tick), .speed(speed), .dir(dir), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The message is a fixed ring of characters; the window start is an offset.
    logic [7:0] m_chars [ML];
    int m_rot, m_speed, m_elapsed, m_blink;
    bit m_dir, m_paused;
    bit p_up, p_dn, p_dir, p_pause;

    function automatic int period(input int s);
        return 1 << (BL + 7 - s);
    endfunction

    function automatic bit m_tick();
        return !m_paused && (m_elapsed == period(m_speed) - 1);
    endfunction

    function automatic logic [ND*8-1:0] m_hex();
        logic [ND*8-1:0] h;
        bit blank;
        blank = 1'b0;
`ifdef SEG7_SCROLLER_PAUSE_BLINK_EN
        blank = m_paused && (((m_blink / (1 << (BL + 3))) % 2) == 1);
`endif
        for (int k = 0; k < ND; k++)
            h[8*k +: 8] = blank ? 8'hFF : m_chars[(k + m_rot) % ML];
        return h;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ML; i++) m_chars[i] = INIT[8*i +: 8];
            m_rot = 0; m_speed = 4; m_elapsed = 0; m_blink = 0;
            m_dir = 0; m_paused = 0;
            p_up = 1; p_dn = 1; p_dir = 1; p_pause = 1;
        end else begin
            bit t, eu, ed;
            int ns;
            t  = m_tick();
            eu = speed_up && !p_up;
            ed = speed_dn && !p_dn;
            ns = m_speed;
            if (eu && !ed) ns = (m_speed < 7) ? m_speed + 1 : 7;
            if (ed && !eu) ns = (m_speed > 0) ? m_speed - 1 : 0;
            m_blink = m_paused ? m_blink + 1 : 0;
            if (load) begin
                for (int i = 0; i < ML; i++) m_chars[i] = msg[8*i +: 8];
                m_rot = 0;
                m_elapsed = 0;
            end else begin
                if (t) m_rot = (m_rot + ML + (m_dir ? -1 : 1)) % ML;
                if (ns != m_speed) m_elapsed = 0;
                else if (!m_paused) m_elapsed = t ? 0 : m_elapsed + 1;
            end
            m_speed = ns;
            if (dir_tgl && !p_dir) m_dir = !m_dir;
            if (pause_tgl && !p_pause) m_paused = !m_paused;
            p_up = speed_up; p_dn = speed_dn; p_dir = dir_tgl; p_pause = pause_tgl;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_hex", 64'(hex), 64'(m_hex()));
            chk("m_tick", 64'(tick), 64'(m_tick()));
            chk("m_speed", 64'(speed), 64'(m_speed));
            chk("m_dir", 64'(dir), 64'(m_dir));
            chk("m_paused", 64'(paused), 64'(m_paused));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until tick is seen high.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            cyc(1);
            if (tick) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL wait_tick no tick within %0d cycles", limit);
        end
    endtask

    initial begin
        int n, nt;
        #1 reset = 1'b1;
        #1;
        chk("rst_hex", 64'(hex), 64'h050403020100);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_speed", 64'(speed), 64'd4);
        chk("rst_dir", 64'(dir), 64'd0);
        chk("rst_paused", 64'(paused), 64'd0);
        cyc(3);
        reset = 1'b0;

        // First tick at cycle 31 with P=32, window shifted at cycle 32.
        cyc(30);
        chk("no_tick_c30", 64'(tick), 64'd0);
        cyc(1);
        chk("tick_c31", 64'(tick), 64'd1);
        cyc(1);
        chk("digit0_c32", 64'(hex[7:0]), 64'h01);
        chk("digit5_c32", 64'(hex[47:40]), 64'h06);
        cyc(288);
        chk("wrap_10_ticks", 64'(hex), 64'h050403020100);

        // Speed saturation at 7, then period 4.
        for (int i = 0; i < 5; i++) begin
            speed_up = 1'b1; cyc(1); speed_up = 1'b0; cyc(1);
        end
        chk("speed_sat7", 64'(speed), 64'd7);
        wait_tick(20, n);
        wait_tick(20, n);
        chk("period_s7", 64'(n), 64'd4);

        for (int i = 0; i < 9; i++) begin
            speed_dn = 1'b1; cyc(1); speed_dn = 1'b0; cyc(1);
        end
        chk("speed_sat0", 64'(speed), 64'd0);
        wait_tick(600, n);
        wait_tick(600, n);
        chk("period_s0", 64'(n), 64'd512);

        speed_up = 1'b1; speed_dn = 1'b1; cyc(1);
        speed_up = 1'b0; speed_dn = 1'b0; cyc(1);
        chk("speed_updn_cancel", 64'(speed), 64'd0);

        for (int i = 0; i < 3; i++) begin
            speed_up = 1'b1; cyc(1); speed_up = 1'b0; cyc(1);
        end
        chk("speed_3", 64'(speed), 64'd3);

        // Direction: reload the ramp, flip, one tick moves slot 9 into digit 0.
        msg = INIT; load = 1'b1; cyc(1); load = 1'b0;
        dir_tgl = 1'b1; cyc(1); dir_tgl = 1'b0;
        chk("dir_1", 64'(dir), 64'd1);
        wait_tick(100, n);
        cyc(1);
        chk("dir_digit0", 64'(hex[7:0]), 64'h09);
        chk("dir_digit1", 64'(hex[15:8]), 64'h00);

        // Pause 10 cycles after a tick; resume picks up the held count.
        wait_tick(100, n);
        cyc(10);
        pause_tgl = 1'b1; cyc(1); pause_tgl = 1'b0;
        chk("paused_1", 64'(paused), 64'd1);
        nt = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (tick) nt++;
        end
        chk("pause_no_ticks", 64'(nt), 64'd0);
        pause_tgl = 1'b1; cyc(1); pause_tgl = 1'b0;
        chk("paused_0", 64'(paused), 64'd0);
        wait_tick(100, n);
        chk("resume_remaining", 64'(n), 64'd53);

        // Load coinciding with a tick: no rotation, prescaler restarts.
        wait_tick(100, n);
        msg = {ML{8'h88}}; load = 1'b1; cyc(1); load = 1'b0;
        chk("load_hex", 64'(hex), 64'h888888888888);
        wait_tick(100, n);
        chk("load_next_tick", 64'(n), 64'd63);

        // Reset mid-period with s=2, dir=1, paused=1.
        speed_dn = 1'b1; cyc(1); speed_dn = 1'b0;
        chk("speed_2", 64'(speed), 64'd2);
        pause_tgl = 1'b1; cyc(1); pause_tgl = 1'b0;
        chk("paused_again", 64'(paused), 64'd1);
`ifdef SEG7_SCROLLER_PAUSE_BLINK_EN
        cyc(40);
        chk("blink_blank", 64'(hex), 64'hFFFFFFFFFFFF);
`else
        cyc(20);
`endif
        reset = 1'b1;
        #1;
        chk("arst_hex", 64'(hex), 64'h050403020100);
        chk("arst_tick", 64'(tick), 64'd0);
        chk("arst_speed", 64'(speed), 64'd4);
        chk("arst_dir", 64'(dir), 64'd0);
        chk("arst_paused", 64'(paused), 64'd0);
        cyc(2);
        reset = 1'b0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
